// File: rtl/width24_src_arbiter.sv
// -----------------------------------------------------------------------------
// width24_src_arbiter
//
// Two-source burst arbiter feeding a 24-to-128 bit packer. A source owns the
// packer for BURST_LEN accepted beats. With the default of 16 beats, a burst
// is 384 bits, which is exactly three 128-bit words, so packer words never mix
// data from the two sources. Ties in arbitration go to the source that did not
// own the previous burst. After every burst there is one arbitration (IDLE)
// cycle.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   valid0     in   1   source 0 beat valid
//   data0      in  24   source 0 beat data
//   ready0     out  1   source 0 beat accepted when valid0 && ready0
//   valid1     in   1   source 1 beat valid
//   data1      in  24   source 1 beat data
//   ready1     out  1   source 1 beat accepted when valid1 && ready1
//   pk_valid   out  1   registered beat valid to the packer
//   pk_data    out 24   registered beat data to the packer
//   grant      out  2   one-hot current owner, 00 when idle
//   beat_cnt   out  4   beats accepted in the current burst
//   burst_done out  1   one-cycle pulse after the last beat of a burst
//
// BURST_LEN must be in the range 1..16 because beat_cnt is 4 bits wide.
// -----------------------------------------------------------------------------
module width24_src_arbiter #(
    parameter int BURST_LEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid0,
    input  logic [23:0] data0,
    output logic        ready0,
    input  logic        valid1,
    input  logic [23:0] data1,
    output logic        ready1,
    output logic        pk_valid,
    output logic [23:0] pk_data,
    output logic [1:0]  grant,
    output logic [3:0]  beat_cnt,
    output logic        burst_done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_e      state_q,      state_d;
    logic [1:0]  grant_q,      grant_d;
    logic [3:0]  beat_cnt_q,   beat_cnt_d;
    logic        last_src_q,   last_src_d;   // 0 = source 0, 1 = source 1
    logic        pk_valid_q,   pk_valid_d;
    logic [23:0] pk_data_q,    pk_data_d;
    logic        burst_done_q, burst_done_d;

    logic        accept_s;
    logic [23:0] beat_data_s;

    // Beat acceptance: only the granted source is looked at, the other is ignored.
    always_comb begin
        accept_s    = 1'b0;
        beat_data_s = data0;
        if (state_q == ST_BURST) begin
            if (grant_q[0]) begin
                accept_s    = valid0;
                beat_data_s = data0;
            end else if (grant_q[1]) begin
                accept_s    = valid1;
                beat_data_s = data1;
            end else begin
                accept_s    = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next-state logic for arbitration, beat counting and the packer stage.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        beat_cnt_d   = beat_cnt_q;
        last_src_d   = last_src_q;
        pk_valid_d   = 1'b0;
        pk_data_d    = pk_data_q;   // data holds when no beat is accepted
        burst_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid0 && valid1) begin
                    // Tie: the source that did not own the last burst wins.
                    grant_d    = last_src_q ? 2'b01 : 2'b10;
                    state_d    = ST_BURST;
                    beat_cnt_d = 4'd0;
                end else if (valid0) begin
                    grant_d    = 2'b01;
                    state_d    = ST_BURST;
                    beat_cnt_d = 4'd0;
                end else if (valid1) begin
                    grant_d    = 2'b10;
                    state_d    = ST_BURST;
                    beat_cnt_d = 4'd0;
                end else begin
                    grant_d    = 2'b00;
                end
            end
            ST_BURST: begin
                if (accept_s) begin
                    pk_valid_d = 1'b1;
                    pk_data_d  = beat_data_s;
                    if (beat_cnt_q == LAST_BEAT) begin
                        burst_done_d = 1'b1;
                        last_src_d   = grant_q[1];
                        grant_d      = 2'b00;
                        beat_cnt_d   = 4'd0;
                        state_d      = ST_IDLE;
                    end else begin
                        beat_cnt_d   = beat_cnt_q + 4'd1;
                    end
                end else begin
                    // Stall: the owner keeps the grant and the count is frozen;
                    // the other source cannot preempt.
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = 2'b00;
                beat_cnt_d = 4'd0;
            end
        endcase
    end

    // State and output registers; reset leaves source 0 winning the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            beat_cnt_q   <= 4'd0;
            last_src_q   <= 1'b1;
            pk_valid_q   <= 1'b0;
            pk_data_q    <= 24'd0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            beat_cnt_q   <= beat_cnt_d;
            last_src_q   <= last_src_d;
            pk_valid_q   <= pk_valid_d;
            pk_data_q    <= pk_data_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign ready0     = grant_q[0];
    assign ready1     = grant_q[1];
    assign grant      = grant_q;
    assign beat_cnt   = beat_cnt_q;
    assign pk_valid   = pk_valid_q;
    assign pk_data    = pk_data_q;
    assign burst_done = burst_done_q;

endmodule

// File: tb/tb_width24_src_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for width24_src_arbiter. Inputs change on the falling
// edge and outputs are sampled on the falling edge. Source 0 data carries tag
// 0x0A in bits [23:16] and source 1 data carries tag 0x0B, so the owner of a
// beat can be recovered from pk_data.
// -----------------------------------------------------------------------------
module tb_width24_src_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid0;
    logic [23:0] data0;
    logic        ready0;
    logic        valid1;
    logic [23:0] data1;
    logic        ready1;
    logic        pk_valid;
    logic [23:0] pk_data;
    logic [1:0]  grant;
    logic [3:0]  beat_cnt;
    logic        burst_done;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  tag0;
    logic [7:0]  tag1;
    int          n0;
    int          n1;

    // Reference 24-to-128 packer bookkeeping.
    int          pk_fill;
    logic [1:0]  pk_mask;
    int          pk_words;

    width24_src_arbiter #(.BURST_LEN(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid0     (valid0),
        .data0      (data0),
        .ready0     (ready0),
        .valid1     (valid1),
        .data1      (data1),
        .ready1     (ready1),
        .pk_valid   (pk_valid),
        .pk_data    (pk_data),
        .grant      (grant),
        .beat_cnt   (beat_cnt),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the source whose beat was accepted presents its next beat.
    task automatic step();
        logic a0;
        logic a1;
        a0 = valid0 & ready0;
        a1 = valid1 & ready1;
        @(negedge clk);
        if (a0) begin
            n0++;
            data0 = {tag0, n0[15:0]};
        end
        if (a1) begin
            n1++;
            data1 = {tag1, n1[15:0]};
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_grant"},      32'(grant),      32'd0);
        check({tag, "_ready0"},     32'(ready0),     32'd0);
        check({tag, "_ready1"},     32'(ready1),     32'd0);
        check({tag, "_pk_valid"},   32'(pk_valid),   32'd0);
        check({tag, "_pk_data"},    32'(pk_data),    32'd0);
        check({tag, "_beat_cnt"},   32'(beat_cnt),   32'd0);
        check({tag, "_burst_done"}, 32'(burst_done), 32'd0);
    endtask

    // Reset with both valids high and random data, then release on a falling edge.
    task automatic apply_reset(input logic v0, input logic v1, input logic [7:0] t0, input logic [7:0] t1);
        rst_n  = 1'b0;
        valid0 = 1'b1;
        valid1 = 1'b1;
        data0  = 24'($urandom);
        data1  = 24'($urandom);
        @(negedge clk);
        @(negedge clk);
        check_cleared("reset");
        tag0   = t0;
        tag1   = t1;
        n0     = 1;
        n1     = 1;
        data0  = {t0, 16'h0001};
        data1  = {t1, 16'h0001};
        valid0 = v0;
        valid1 = v1;
        rst_n  = 1'b1;
    endtask

    // Feed one beat into the reference packer; each completed word must be single-source.
    task automatic pack_beat(input logic [23:0] d);
        logic [1:0] src;
        src      = (d[23:16] == 8'h0A) ? 2'b01 : 2'b10;
        pk_mask  = pk_mask | src;
        pk_fill  = pk_fill + 24;
        if (pk_fill >= 128) begin
            pk_words++;
            check("pack_word_single_src", 32'(pk_mask), 32'(src));
            pk_fill = pk_fill - 128;
            pk_mask = (pk_fill > 0) ? src : 2'b00;
        end
    endtask

    initial begin
        logic [1:0]  owner;
        logic [7:0]  otag;
        int          idx;
        int          beats;

        rst_n  = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        data0  = 24'd0;
        data1  = 24'd0;
        tag0   = 8'h00;
        tag1   = 8'h00;
        n0     = 0;
        n1     = 0;

        // Reset and contention over three bursts; first two feed the packer.
        apply_reset(1'b1, 1'b1, 8'h0A, 8'h0B);
        pk_fill  = 0;
        pk_mask  = 2'b00;
        pk_words = 0;
        step();
        check("first_grant", 32'(grant), 32'h1);
        for (int b = 0; b < 3; b++) begin
            owner = (b % 2 == 0) ? 2'b01 : 2'b10;
            otag  = (b % 2 == 0) ? 8'h0A : 8'h0B;
            check("cont_grant_start", 32'(grant), 32'(owner));
            check("cont_ready0", 32'(ready0), 32'(owner[0]));
            check("cont_ready1", 32'(ready1), 32'(owner[1]));
            for (int i = 1; i <= 16; i++) begin
                step();
                idx = (b == 2) ? 16 + i : i;
                check("cont_pk_valid", 32'(pk_valid), 32'd1);
                check("cont_pk_data", 32'(pk_data), 32'({otag, 16'(idx)}));
                check("cont_beat_cnt", 32'(beat_cnt), 32'(i % 16));
                check("cont_burst_done", 32'(burst_done), (i == 16) ? 32'd1 : 32'd0);
                check("cont_grant", 32'(grant), (i == 16) ? 32'd0 : 32'(owner));
                if (b < 2) begin
                    pack_beat(pk_data);
                end
            end
            step();
            check("cont_gap_pk_valid", 32'(pk_valid), 32'd0);
            check("cont_gap_burst_done", 32'(burst_done), 32'd0);
        end
        check("pack_word_count", 32'(pk_words), 32'd6);

        // Single source with data 0x000001..0x000010.
        apply_reset(1'b1, 1'b0, 8'h00, 8'hFF);
        check("single_ready_pre", 32'(ready0), 32'd0);
        step();
        check("single_ready0", 32'(ready0), 32'd1);
        check("single_grant", 32'(grant), 32'h1);
        check("single_pk_valid_pre", 32'(pk_valid), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            check("single_pk_valid", 32'(pk_valid), 32'd1);
            check("single_pk_data", 32'(pk_data), 32'(i));
            check("single_burst_done", 32'(burst_done), (i == 16) ? 32'd1 : 32'd0);
        end
        check("single_idle_grant", 32'(grant), 32'd0);
        check("single_idle_ready0", 32'(ready0), 32'd0);
        step();
        check("single_regrant", 32'(grant), 32'h1);
        check("single_done_low", 32'(burst_done), 32'd0);
        check("single_pk_valid_gap", 32'(pk_valid), 32'd0);
        check("single_pk_data_hold", 32'(pk_data), 32'h000010);

        // Mid-burst stall of source 0 during beats 5-7 while source 1 waits.
        apply_reset(1'b1, 1'b1, 8'h0A, 8'h0B);
        step();
        check("stall_grant", 32'(grant), 32'h1);
        beats = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (pk_valid) beats++;
            check("stall_pre_beat_cnt", 32'(beat_cnt), 32'(i));
        end
        valid0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (pk_valid) beats++;
            check("stall_pk_valid", 32'(pk_valid), 32'd0);
            check("stall_grant_held", 32'(grant), 32'h1);
            check("stall_beat_cnt", 32'(beat_cnt), 32'd5);
            check("stall_pk_data_hold", 32'(pk_data), 32'h0A0005);
        end
        valid0 = 1'b1;
        for (int i = 6; i <= 16; i++) begin
            step();
            if (pk_valid) beats++;
            check("stall_post_pk_data", 32'(pk_data), 32'({8'h0A, 16'(i)}));
        end
        check("stall_total_beats", 32'(beats), 32'd16);
        check("stall_burst_done", 32'(burst_done), 32'd1);
        check("stall_end_grant", 32'(grant), 32'd0);
        step();
        check("stall_next_grant", 32'(grant), 32'h2);

        // Reset asserted at beat_cnt = 8 clears outputs immediately.
        apply_reset(1'b1, 1'b1, 8'h0A, 8'h0B);
        step();
        for (int i = 1; i <= 8; i++) begin
            step();
        end
        check("midrst_beat_cnt_pre", 32'(beat_cnt), 32'd8);
        rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        @(negedge clk);
        n0     = 256;
        data0  = {8'h0A, 16'h0100};
        rst_n  = 1'b1;
        step();
        check("midrst_grant", 32'(grant), 32'h1);
        check("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
        step();
        check("midrst_pk_data", 32'(pk_data), 32'h0A0100);
        check("midrst_beat_cnt_1", 32'(beat_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
